memrd_path_ctrl: RTL

- Parametrised, sequential load-data path for the CPU memory stage. Generalises the two-way periread/dmemout select to NUM_PERI memory-mapped peripherals plus synchronous data memory.
- Decodes load address, drives the selected target with a request/ack handshake and timeout, then aligns and sign/zero-extends byte/half/word.
- Returns a registered result with valid/error flags; asserts busy to stall the pipeline while a load is outstanding.

---
 rtl/memrd_pkg.sv | 21 ++
 rtl/load_align_ext.sv | 28 ++
 rtl/memrd_path_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/memrd_pkg.sv
// Shared encodings for the memory-stage load path: access sizes, controller
// states and the constants used by the error response.
package memrd_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DMEM = 2'b01,
        ST_PERI = 2'b10
    } state_e;

    localparam int          PERI_TAG_W = 16;
    localparam logic [31:0] ERR_DATA   = 32'h0000_0000;

endpackage

// File: rtl/load_align_ext.sv
// Picks the byte/half/word addressed by lane out of a fetched word and
// sign- or zero-extends it to the full data width.
module load_align_ext
    import memrd_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        sgn,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        data   = ERR_DATA;
        case (size)
            SZ_BYTE: data = {{24{sgn & byte_v[7]}}, byte_v};
            SZ_HALF: data = {{16{sgn & half_v[15]}}, half_v};
            SZ_WORD: data = word;
            default: data = ERR_DATA;
        endcase
    end

endmodule

// File: rtl/memrd_path_ctrl.sv
// Load-data path of the memory stage: routes a load to data memory or one of
// NUM_PERI peripherals, waits for the data, then returns it aligned/extended.
module memrd_path_ctrl
    import memrd_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 32,
    parameter int          NUM_PERI = 4,
    parameter logic [15:0] PERI_TAG = 16'hFFFF,
    parameter int          PSEL_LSB = 8,
    parameter int          TIMEOUT  = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     ld_req,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [1:0]               ld_size,
    input  logic                     ld_signed,
    output logic                     ld_busy,
    output logic                     ld_valid,
    output logic                     ld_err,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     dmem_rd_en,
    output logic [ADDR_W-1:0]        dmem_addr,
    input  logic [DATA_W-1:0]        dmem_rdata,
    output logic [NUM_PERI-1:0]      peri_rd_en,
    output logic [PSEL_LSB-1:0]      peri_addr,
    input  logic [NUM_PERI*DATA_W-1:0] peri_rdata,
    input  logic [NUM_PERI-1:0]      peri_ack
);

    localparam int TW = $clog2(TIMEOUT);

    state_e              state, state_nxt;
    logic [1:0]          lane_q;
    size_e               size_q;
    logic                sgn_q;
    logic [TW-1:0]       timer;
    logic [PSEL_LSB-1:0] paddr_q;
    logic [NUM_PERI-1:0] psel_q;

    size_e               sz;
    logic [3:0]          pidx;
    logic                in_peri, misalign, unmapped;
    logic                accept, acc_err, acc_peri, acc_dmem;
    logic [NUM_PERI-1:0] onehot;
    logic                sel_ack, timed_out;
    logic [DATA_W-1:0]   sel_rdata, src_word, aligned;

    always_comb begin
        sz        = size_e'(ld_size);
        pidx      = ld_addr[PSEL_LSB +: 4];
        in_peri   = (ld_addr[ADDR_W-1 -: PERI_TAG_W] == PERI_TAG);
        misalign  = (sz == SZ_ILL) || (sz == SZ_HALF && ld_addr[0]) ||
                    (sz == SZ_WORD && ld_addr[1:0] != 2'b00);
        unmapped  = in_peri && ({1'b0, pidx} >= 5'(NUM_PERI));
        accept    = (state == ST_IDLE) && ld_req;
        acc_err   = accept && (misalign || unmapped);
        acc_peri  = accept && !misalign && in_peri && !unmapped;
        acc_dmem  = accept && !misalign && !in_peri;
        onehot    = '0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_PERI; i++) begin
            onehot[i] = (pidx == 4'(i));
            if (psel_q[i])
                sel_rdata = sel_rdata | peri_rdata[i*DATA_W +: DATA_W];
        end
        // Only the channel we actually requested may complete the access.
        sel_ack   = |(peri_ack & psel_q);
        timed_out = (timer == TW'(TIMEOUT - 1));
        src_word  = (state == ST_DMEM) ? dmem_rdata : sel_rdata;
    end

    load_align_ext u_align (
        .word (src_word),
        .lane (lane_q),
        .size (size_q),
        .sgn  (sgn_q),
        .data (aligned)
    );

    always_comb begin
        state_nxt  = state;
        dmem_rd_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (acc_dmem) begin
                    dmem_rd_en = 1'b1;
                    state_nxt  = ST_DMEM;
                end else if (acc_peri) begin
                    state_nxt  = ST_PERI;
                end
            end
            ST_DMEM: state_nxt = ST_IDLE;
            ST_PERI: if (sel_ack || timed_out) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign dmem_addr  = {ld_addr[ADDR_W-1:2], 2'b00};
    assign ld_busy    = (state != ST_IDLE);
    assign peri_rd_en = psel_q;
    assign peri_addr  = paddr_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            ld_valid <= 1'b0;
            ld_err   <= 1'b0;
            ld_data  <= '0;
            psel_q   <= '0;
            timer    <= '0;
            lane_q   <= 2'b00;
            size_q   <= SZ_BYTE;
            sgn_q    <= 1'b0;
            paddr_q  <= '0;
        end else begin
            state    <= state_nxt;
            ld_valid <= 1'b0;
            if (accept) begin
                lane_q  <= ld_addr[1:0];
                size_q  <= sz;
                sgn_q   <= ld_signed;
                paddr_q <= {ld_addr[PSEL_LSB-1:2], 2'b00};
                timer   <= '0;
            end
            if (acc_err) begin
                ld_valid <= 1'b1;
                ld_err   <= 1'b1;
                ld_data  <= ERR_DATA;
            end
            if (acc_peri)
                psel_q <= onehot;
            case (state)
                ST_DMEM: begin
                    ld_valid <= 1'b1;
                    ld_err   <= 1'b0;
                    ld_data  <= aligned;
                end
                ST_PERI: begin
                    timer <= timer + TW'(1);
                    // A late ack still beats the timeout in the same cycle.
                    if (sel_ack) begin
                        ld_valid <= 1'b1;
                        ld_err   <= 1'b0;
                        ld_data  <= aligned;
                        psel_q   <= '0;
                    end else if (timed_out) begin
                        ld_valid <= 1'b1;
                        ld_err   <= 1'b1;
                        ld_data  <= ERR_DATA;
                        psel_q   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
